// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Imported by bcd_add3 and bcd_seq_convert.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] ADJ_THRESH  = 4'd5;
    localparam logic [3:0] ADJ_ADD     = 4'd3;

    // 10^n, used to prove DIGITS is wide enough for WIDTH.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One BCD digit adjust step of double dabble: add 3 when digit >= 5.
// Ports: in (4-bit digit before shift), out (adjusted digit).
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [3:0] in,
    output logic [3:0] out
);

    // A digit >= 5 is at most 9 here, so +3 never exceeds 12.
    assign out = (in >= ADJ_THRESH) ? in + ADJ_ADD : in;

endmodule

// File: rtl/bcd_seq_convert.sv
// Iterative binary-to-BCD converter, one input bit per clock.
// Ports: clk, reset (sync, high), start, in -> busy, done, bcd.
module bcd_seq_convert
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
        $error("DIGITS too small for WIDTH");
    end

    state_t        state;
    logic [SW-1:0] sr;
    logic [SW-1:0] adj;
    logic [SW-1:0] nxt;
    logic [CW-1:0] cnt;

    // All digits adjust in parallel from the pre-shift register value.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .in  (sr [WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .out (adj[WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    assign adj[WIDTH-1:0] = sr[WIDTH-1:0];
    assign nxt            = adj << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {{BW{1'b0}}, in};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= nxt;
                    cnt <= cnt + 1'b1;
                    // Result goes out in one step so bcd is never partial.
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        bcd   <= nxt[SW-1 -: BW];
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bcd_seq_convert.md
# bcd_seq_convert

Sequential binary-to-BCD converter controller using shift-and-add-3 (double dabble). It accepts a WIDTH-bit binary value on a start pulse and iterates one bit per clock. It then presents DIGITS packed BCD digits with a one-cycle done pulse. It sits between counter/arithmetic logic and the seven-segment display path, replacing a wide combinational converter with a small iterative datapath plus FSM.

## Interface
- WIDTH, 8, binary input width (≥1)
- DIGITS, 3, number of BCD output digits; elaboration error unless 10^DIGITS > 2^WIDTH − 1
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- in  input  WIDTH  binary operand; latched on accepted start
- busy  output  1  high while conversion iterates
- done  output  1  one-cycle pulse, bcd valid and newly updated
- bcd  output  4*DIGITS  packed result; digit 0 (ones) in bits [3:0], digit k in [4k+3:4k]

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on start=1, load shift register {DIGITS×4'b0, in}, clear bit counter, go to SHIFT. start=0 stays IDLE.
- SHIFT: each cycle, every BCD digit field ≥5 gets +3 (all digits in parallel, from pre-shift value). Then the whole register shifts left by 1. Counter increments. After WIDTH shifts, load bcd from the upper 4*DIGITS bits and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- start while in SHIFT or DONE is ignored (not queued). Changes on in after acceptance have no effect.
- bcd holds the last completed result until the next done. It is never partially updated.
- Arithmetic: the shift register is 4*DIGITS+WIDTH bits, and the counter is $clog2(WIDTH+1) bits. Digit adjust never carries between digits, because the input is ≤9 when the digit is ≥5.

## Timing
- Reset (any state, including mid-SHIFT) → IDLE on the next edge, with busy=0, done=0, bcd=0, and shift register and counter cleared. An in-flight conversion is discarded and produces no done.
- Reset has priority over start in the same cycle.
- start accepted at edge t: busy=1 from edge t to edge t+WIDTH (WIDTH cycles). done=1 and new bcd from edge t+WIDTH to t+WIDTH+1.
- Latency: start-sample to done = WIDTH cycles. Throughput: one conversion per WIDTH+2 cycles. The earliest next accepted start is at edge t+WIDTH+2, since start during the DONE cycle is ignored.
- busy and done are never high together. Both are registered outputs, and there is no combinational path from inputs to outputs.

## Structure
- Shared package bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE)
  - BCD_DIGIT_W = 4
  - ADJ_THRESH = 5
  - ADJ_ADD = 3
- Sub-module bcd_add3 is a 4-bit combinational digit adjust (out = in≥5 ? in+3 : in). It is instantiated DIGITS times in a generate loop.
- The top level holds the FSM, counter, shift register and output register.

## Test plan
- in=63, start pulse (WIDTH=8) → after 8 busy cycles, done pulse with bcd=12'h063. Sweep 0..255 and compare each result against the reference decimal split.
- in=0 → bcd=12'h000; in=255 → bcd=12'h255; in=99 → bcd=12'h099; in=100 → bcd=12'h100. Covers digit-boundary carries.
- start held high continuously with in=42 then in=7 → first done bcd=12'h042. Next acceptance only at t+10, and the second done bcd is the value present at that edge. Only one done per accepted start.
- Assert reset at SHIFT cycle 4 of in=200 → next cycle busy=0, done=0, bcd=0. No done pulse follows, and a fresh start of in=200 yields bcd=12'h200.
- Change in every cycle during busy after start with in=128 → bcd=12'h128; previous bcd stays stable until the done edge.
- WIDTH=6, DIGITS=2 instance: exhaustive 0..63 → bcd matches tens/ones, and done comes 6 cycles after start.
